fft_addr_gen: RTL
=================

# fft_addr_gen

Address-generation and sequencing unit for the in-place radix-2 DIT FFT core (N = 1024). Once per frame it walks all log2(N) stages, issuing per butterfly the two data-memory read addresses and the 9-bit index for `twiddle_factor_rom`. It also produces the matching write-back addresses, delayed to line up with the butterfly pipeline output. It sits directly upstream of the twiddle ROM and the butterfly datapath, and is driven by the frame controller.

## Interface
- `N_LOG2`, 10, log2 of FFT length; data address width = N_LOG2, twiddle address width = N_LOG2-1
- `BF_LATENCY`, 4, cycles from read issue to butterfly result, ROM and RAM read latency included; legal range 1..15

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  single-cycle frame start request; honoured only in IDLE
- `ready`  in  1  datapath can accept a butterfly this cycle; stalls issue only
- `busy`  out  1  high from the cycle after start is accepted until `done`
- `done`  out  1  single-cycle pulse; frame fully written back
- `rd_valid`  out  1  read addresses and twiddle address valid this cycle
- `rd_addr_a`  out  N_LOG2  top butterfly input address
- `rd_addr_b`  out  N_LOG2  bottom butterfly input address
- `tw_addr`  out  N_LOG2-1  twiddle ROM address
- `stage`  out  4  current stage index, 0..N_LOG2-1
- `wr_valid`  out  1  write-back addresses valid
- `wr_addr_a`  out  N_LOG2  write address for the top result
- `wr_addr_b`  out  N_LOG2  write address for the bottom result

## Operation
- States: IDLE, RUN, DRAIN, FLUSH, DONE.
- IDLE: `start`=1 moves to RUN, with stage=0 and butterfly counter b=0. `start` in any other state is ignored.
- RUN: `rd_valid` = `ready`. Each cycle with `ready`=1 issues butterfly b, then increments b (9 bits).
- Address rules, with stage s and half = 2^s:
  - `rd_addr_a` = {b[8:s], 0, b[s-1:0]}
  - `rd_addr_b` = {b[8:s], 1, b[s-1:0]}
  - `tw_addr` = (b << (9-s)) mod 512
- End of stage, on issue of b=511:
  - if s < N_LOG2-1: s increments, b wraps to 0, and the FSM goes to DRAIN (macro defined) or stays in RUN (macro undefined).
  - if s = N_LOG2-1: go to FLUSH.
- DRAIN: exactly BF_LATENCY cycles with `rd_valid`=0, then RUN. This guarantees the previous stage's writes land before the next stage reads.
- FLUSH: waits BF_LATENCY cycles for the last write-back, then DONE.
- DONE: `done`=1 for one cycle, `busy` falls with it, then IDLE.
- Write-back path: a delay line of BF_LATENCY registers carries {rd_valid, rd_addr_a, rd_addr_b}. It shifts every cycle regardless of state or `ready`. Its output drives `wr_valid`, `wr_addr_a` and `wr_addr_b`.
- Reset, including mid-frame: FSM goes to IDLE; b, s and all delay-line entries clear; every output is 0. No partial write-back emerges after reset.

## Timing
- Cycle 0: `start` sampled high. Cycle 1: `busy`=1, first `rd_valid`.
- `wr_valid` for a butterfly issued in cycle t is asserted in cycle t+BF_LATENCY.
- With `ready` held at 1 and L = BF_LATENCY:
  - macro defined: last read in cycle 5120+9L, last write in 5120+10L, `done` in 5121+10L (5161 for L=4)
  - macro undefined: last read in 5120, `done` in 5121+L (5125 for L=4)
- `ready`=0 freezes b and s and deasserts `rd_valid`. In-flight write-backs still emerge on schedule. DRAIN and FLUSH counters ignore `ready`.
- `rd_*` address outputs are combinational from b and s; all other outputs are registered.

## Configuration
- `FFT_ADDR_GEN_DRAIN_EN`
  - Defined: DRAIN state is inserted between stages, for single-port in-place memory.
  - Undefined: stages issue back-to-back, for ping-pong memory. The DRAIN state is removed; FLUSH is always present.

## Structure
- `fft_pkg` holds:
  - `FFT_N_LOG2`
  - data and twiddle address width constants
  - the FSM state enum
- Sub-module `fft_addr_delay`: a parameterised BF_LATENCY-deep shift register with synchronous reset, instantiated once for the write-back path.

## Test plan
- Reset then `start`, `ready`=1, stage 0: b=0 -> a=0, b=1, tw=0; b=5 -> a=10, b=11, tw=0.
- Stage 3, b=13 -> a=21, b=29, tw=320. Stage 9, b=300 -> a=300, b=812, tw=300.
- Full frame with the macro defined, L=4, `ready`=1: exactly 5120 `rd_valid` and 5120 `wr_valid` cycles, 4-cycle gap between stages, `done` at cycle 5161, every wr address equals the rd address issued 4 cycles earlier.
- Same frame with the macro undefined: no inter-stage gaps, `done` at cycle 5125.
- `ready`=0 for 7 cycles mid stage 2 at b=100 -> b stays 100, `rd_valid`=0 for 7 cycles, pending writes still emerge, and issue resumes at b=100.
- `rst` at cycle 3000, with writes in flight -> all outputs 0 next cycle, no `wr_valid` afterwards; `start` during `busy` ignored; a fresh `start` after reset runs a complete frame.

Source files
------------

// File: rtl/fft_addr_gen_pkg.sv
// Shared constants and FSM state encoding for the FFT address generator.
// FFT_ADDR_GEN_DRAIN_EN: when defined, the DRAIN state exists between stages.
package fft_pkg;

  localparam int FFT_N_LOG2  = 10;
  localparam int FFT_DATA_AW = FFT_N_LOG2;
  localparam int FFT_TW_AW   = FFT_N_LOG2 - 1;
  localparam int FFT_STAGE_W = 4;
  localparam int FFT_CNT_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
`ifdef FFT_ADDR_GEN_DRAIN_EN
    ST_DRAIN = 3'd2,
`endif
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } fft_state_e;

endpackage

// File: rtl/fft_addr_gen_if.sv
// Frame-control, read-issue and write-back signals of the FFT address generator.
// master: the address generator; slave: frame controller / datapath side.
interface fft_addr_gen_if import fft_pkg::*; #(
  parameter int N_LOG2 = FFT_N_LOG2
) ();

  logic                   start;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic                   rd_valid;
  logic [N_LOG2-1:0]      rd_addr_a;
  logic [N_LOG2-1:0]      rd_addr_b;
  logic [N_LOG2-2:0]      tw_addr;
  logic [FFT_STAGE_W-1:0] stage;
  logic                   wr_valid;
  logic [N_LOG2-1:0]      wr_addr_a;
  logic [N_LOG2-1:0]      wr_addr_b;

  modport master (
    input  start, ready,
    output busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
           wr_valid, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, ready,
    input  busy, done, rd_valid, rd_addr_a, rd_addr_b, tw_addr, stage,
           wr_valid, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/fft_addr_delay.sv
// Fixed-depth shift register aligning issued read addresses with butterfly results.
module fft_addr_delay import fft_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * FFT_DATA_AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q, pipe_d;

  // Shift one slot per cycle, new entry enters at slot 0
  always_comb begin
    pipe_d    = pipe_q << WIDTH;
    pipe_d[0] = din;
  end

  // Pipeline registers; reset flushes everything in flight
  always_ff @(posedge clk) begin
    if (rst) pipe_q <= '0;
    else     pipe_q <= pipe_d;
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT FFT address generator: walks all stages once per frame, issuing
// butterfly read/twiddle addresses and delayed write-back addresses.
// FFT_ADDR_GEN_DRAIN_EN: defined inserts a BF_LATENCY-cycle DRAIN between stages
// (single-port in-place memory); undefined issues stages back to back.
module fft_addr_gen import fft_pkg::*; #(
  parameter int N_LOG2     = FFT_N_LOG2,
  parameter int BF_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  fft_addr_gen_if.master  bus
);

  localparam int AW = N_LOG2;
  localparam int BW = N_LOG2 - 1;
  localparam int DW = 2 * AW + 1;
  localparam logic [BW-1:0]          B_LAST   = '1;
  localparam logic [FFT_STAGE_W-1:0] S_LAST   = FFT_STAGE_W'(N_LOG2 - 1);
  localparam logic [FFT_CNT_W-1:0]   CNT_LAST = FFT_CNT_W'(BF_LATENCY - 1);

  fft_state_e             state_q, state_d;
  logic [BW-1:0]          b_q, b_d;
  logic [FFT_STAGE_W-1:0] s_q, s_d;
  logic [FFT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   issue;
  logic [AW-1:0]          bx, half, lo_mask, addr_a, addr_b;
  logic [BW-1:0]          tw;
  logic [DW-1:0]          dl_in, dl_out;

  assign issue = (state_q == ST_RUN) && bus.ready;

  // Butterfly addresses: insert the stage bit at position s; zero outside RUN
  always_comb begin
    bx      = {1'b0, b_q};
    half    = AW'(1) << s_q;
    lo_mask = half - AW'(1);
    addr_a  = (bx & lo_mask) | ((bx & ~lo_mask) << 1);
    addr_b  = addr_a | half;
    tw      = b_q << (S_LAST - s_q);
    if (state_q != ST_RUN) begin
      addr_a = '0;
      addr_b = '0;
      tw     = '0;
    end
  end

  // Frame sequencing: next state, butterfly/stage counters, wait counter
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          b_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (bus.ready) begin
          b_d = b_q + 1'b1;
          if (b_q == B_LAST) begin
            if (s_q == S_LAST) begin
              state_d = ST_FLUSH;
              cnt_d   = '0;
            end else begin
              s_d = s_q + 1'b1;
`ifdef FFT_ADDR_GEN_DRAIN_EN
              state_d = ST_DRAIN;
              cnt_d   = '0;
`endif
            end
          end
        end
      end
`ifdef FFT_ADDR_GEN_DRAIN_EN
      ST_DRAIN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_RUN;
      end
`endif
      ST_FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        b_d     = '0;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign dl_in = {issue, addr_a, addr_b};

  fft_addr_delay #(
    .DEPTH (BF_LATENCY),
    .WIDTH (DW)
  ) u_wb_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dl_in),
    .dout (dl_out)
  );

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.rd_valid  = issue;
  assign bus.rd_addr_a = addr_a;
  assign bus.rd_addr_b = addr_b;
  assign bus.tw_addr   = tw;
  assign bus.stage     = s_q;
  assign bus.wr_valid  = dl_out[DW-1];
  assign bus.wr_addr_a = dl_out[2*AW-1:AW];
  assign bus.wr_addr_b = dl_out[AW-1:0];

endmodule
